// File: rtl/pwm_trip_guard.sv
// pwm_trip_guard: registered PWM passthrough that latches a trip on filtered fault or shoot-through and forces safe levels
module pwm_trip_guard #(
  parameter int N_LEGS = 2,
  parameter int FILT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_LEGS-1:0]     pwm_a,
  input  logic [N_LEGS-1:0]     pwm_b,
  input  logic                  fault_n,
  input  logic [FILT_WIDTH-1:0] filt_len,
  input  logic                  trip_en,
  input  logic [N_LEGS-1:0]     safe_a,
  input  logic [N_LEGS-1:0]     safe_b,
  input  logic                  clear_req,
  output logic [N_LEGS-1:0]     gate_a,
  output logic [N_LEGS-1:0]     gate_b,
  output logic                  tripped,
  output logic [1:0]            trip_cause,
  output logic                  clear_ack,
  output logic [7:0]            trip_count
);
  typedef enum logic {ARMED, TRIPPED} state_t;
  state_t state, state_nx;
  logic sync_1, sync_2, fault_s, fault_f, shoot, go_trip, accept;
  logic [FILT_WIDTH-1:0] filt_cnt;
  logic [N_LEGS-1:0] gate_a_nx, gate_b_nx;
  assign fault_s = ~sync_2;
  assign fault_f = fault_s && (filt_cnt == filt_len);
  assign shoot = |(pwm_a & pwm_b);
  assign tripped = (state == TRIPPED);
  // Synchronise the asynchronous fault pin and count how long it has stayed active
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      filt_cnt <= '0;
    end else begin
      sync_1 <= fault_n;
      sync_2 <= sync_1;
      filt_cnt <= !fault_s ? '0 : (&filt_cnt ? filt_cnt : filt_cnt + 1'b1);
    end
  end
  // Trip/clear decisions; the tripping edge already loads safe levels so an overlap never reaches the pins
  always_comb begin
    go_trip = (state == ARMED) && trip_en && (fault_f || shoot);
    accept = (state == TRIPPED) && clear_req && !fault_s && !shoot;
    state_nx = go_trip ? TRIPPED : (accept ? ARMED : state);
    gate_a_nx = (state == TRIPPED || go_trip) ? safe_a : pwm_a;
    gate_b_nx = (state == TRIPPED || go_trip) ? safe_b : pwm_b;
  end
  // State, gate outputs and trip bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARMED;
      gate_a <= safe_a;
      gate_b <= safe_b;
      trip_cause <= 2'b00;
      clear_ack <= 1'b0;
      trip_count <= 8'd0;
    end else begin
      state <= state_nx;
      gate_a <= gate_a_nx;
      gate_b <= gate_b_nx;
      clear_ack <= accept;
      trip_cause <= go_trip ? {shoot, fault_f} : (accept ? 2'b00 : trip_cause);
      if (go_trip && trip_count != 8'hff) trip_count <= trip_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_pwm_trip_guard.sv
// tb_pwm_trip_guard: directed and randomized checks of pwm_trip_guard against a cycle-level reference model
module tb_pwm_trip_guard;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] pwm_a = '0, pwm_b = '0, safe_a = '0, safe_b = '0;
  logic fault_n = 1'b1, trip_en = 1'b1, clear_req = 1'b0;
  logic [7:0] filt_len = 8'd4;
  logic [1:0] gate_a, gate_b, trip_cause;
  logic tripped, clear_ack;
  logic [7:0] trip_count;
  int n_chk = 0, n_fail = 0;
  bit hist[$];
  bit m_trip, m_ack;
  logic [1:0] m_ga, m_gb, m_cause;
  int m_count;

  pwm_trip_guard #(.N_LEGS(2), .FILT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .pwm_a(pwm_a), .pwm_b(pwm_b), .fault_n(fault_n),
    .filt_len(filt_len), .trip_en(trip_en), .safe_a(safe_a), .safe_b(safe_b),
    .clear_req(clear_req), .gate_a(gate_a), .gate_b(gate_b), .tripped(tripped),
    .trip_cause(trip_cause), .clear_ack(clear_ack), .trip_count(trip_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: predict from the pre-edge inputs, clock, then compare every output
  task automatic step();
    bit fs, ff, sh;
    int run;
    fs = (hist[hist.size()-2] == 1'b0);
    run = 0;
    for (int i = hist.size() - 2; i >= 0; i--) begin
      if (hist[i]) break;
      run++;
    end
    ff = fs && (run - 1 == int'(filt_len));
    sh = |(pwm_a & pwm_b);
    m_ack = 1'b0;
    if (reset) begin
      m_trip = 1'b0; m_ga = safe_a; m_gb = safe_b; m_cause = 2'b00; m_count = 0;
      hist = '{1'b1, 1'b1};
    end else begin
      if (!m_trip) begin
        if (trip_en && (ff || sh)) begin
          m_trip = 1'b1; m_ga = safe_a; m_gb = safe_b; m_cause = {sh, ff};
          m_count = (m_count < 255) ? m_count + 1 : 255;
        end else begin
          m_ga = pwm_a; m_gb = pwm_b;
        end
      end else begin
        m_ga = safe_a; m_gb = safe_b;
        if (clear_req && !fs && !sh) begin
          m_trip = 1'b0; m_ack = 1'b1; m_cause = 2'b00;
        end
      end
      hist.push_back(fault_n);
      if (hist.size() > 400) void'(hist.pop_front());
    end
    @(posedge clk);
    #1;
    chk("m_gate_a", gate_a, m_ga);
    chk("m_gate_b", gate_b, m_gb);
    chk("m_tripped", tripped, m_trip);
    chk("m_cause", trip_cause, m_cause);
    chk("m_ack", clear_ack, m_ack);
    chk("m_count", trip_count, m_count);
  endtask

  initial begin
    int burst;
    hist = '{1'b1, 1'b1};
    reset = 1'b1;
    step(); step();
    chk("rst_tripped", tripped, 0);
    chk("rst_count", trip_count, 0);
    chk("rst_gate_a", gate_a, 2'b00);
    reset = 1'b0; pwm_a = 2'b01; pwm_b = 2'b10;
    step();
    chk("pass_a", gate_a, 2'b01);
    chk("pass_b", gate_b, 2'b10);
    fault_n = 1'b0;
    repeat (4) step();
    fault_n = 1'b1;
    repeat (6) step();
    chk("short_pulse", tripped, 0);
    fault_n = 1'b0;
    repeat (6) step();
    chk("trip_early", tripped, 0);
    step();
    chk("trip_lat", tripped, 1);
    chk("fault_cause", trip_cause, 2'b01);
    chk("fault_count", trip_count, 1);
    chk("fault_safe_a", gate_a, 2'b00);
    clear_req = 1'b1;
    step();
    chk("clr_blocked_ack", clear_ack, 0);
    chk("clr_blocked_trip", tripped, 1);
    clear_req = 1'b0; fault_n = 1'b1;
    repeat (3) step();
    clear_req = 1'b1;
    step();
    chk("clr_ack", clear_ack, 1);
    chk("clr_cause", trip_cause, 2'b00);
    chk("clr_trip", tripped, 0);
    chk("clr_gate_safe", gate_a, 2'b00);
    clear_req = 1'b0;
    step();
    chk("ack_pulse", clear_ack, 0);
    chk("resume_a", gate_a, 2'b01);
    chk("resume_b", gate_b, 2'b10);
    pwm_b = 2'b01;
    step();
    chk("shoot_cause", trip_cause, 2'b10);
    chk("shoot_trip", tripped, 1);
    chk("shoot_ga", gate_a, 2'b00);
    chk("shoot_gb", gate_b, 2'b00);
    chk("shoot_count", trip_count, 2);
    pwm_b = 2'b10; clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    step(); step();
    filt_len = 8'd0; fault_n = 1'b0;
    step(); step();
    pwm_a = 2'b11; pwm_b = 2'b11;
    step();
    chk("both_cause", trip_cause, 2'b11);
    chk("both_count", trip_count, 3);
    pwm_a = 2'b01; pwm_b = 2'b10; fault_n = 1'b1;
    repeat (3) step();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    step();
    trip_en = 1'b0; pwm_a = 2'b11; pwm_b = 2'b11;
    repeat (3) step();
    chk("dis_trip", tripped, 0);
    chk("dis_pass", gate_a, 2'b11);
    pwm_a = 2'b01; pwm_b = 2'b10; trip_en = 1'b1;
    step();
    for (int i = 0; i < 256; i++) begin
      pwm_b = 2'b01;
      step();
      pwm_b = 2'b10; clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      step();
    end
    chk("sat_count", trip_count, 255);
    pwm_b = 2'b01;
    step();
    pwm_b = 2'b10; safe_a = 2'b10; safe_b = 2'b01;
    step();
    chk("track_safe_a", gate_a, 2'b10);
    chk("track_safe_b", gate_b, 2'b01);
    reset = 1'b1;
    step();
    chk("mid_rst_trip", tripped, 0);
    chk("mid_rst_count", trip_count, 0);
    chk("mid_rst_cause", trip_cause, 0);
    chk("mid_rst_gate", gate_a, 2'b10);
    reset = 1'b0;
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      pwm_a = 2'($urandom);
      pwm_b = ($urandom_range(0, 39) == 0) ? 2'($urandom) : ~pwm_a;
      if (burst > 0) begin
        fault_n = 1'b0; burst--;
      end else begin
        fault_n = 1'b1;
        if ($urandom_range(0, 59) == 0) burst = $urandom_range(1, 8);
      end
      clear_req = ($urandom_range(0, 7) == 0);
      trip_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) begin
        safe_a = 2'($urandom); safe_b = 2'($urandom);
      end
      if (i % 200 == 0) filt_len = 8'($urandom_range(0, 5));
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
